// File: rtl/fifo_lvl.sv
// Synchronous FIFO with occupancy level, almost flags and sticky errors.
// Define FIFO_STROBE_EDGE_EN to turn wr/rd into rising-edge strobes.
module fifo_lvl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 2**ADDR_W-2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AEMPTY_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_s, rd_s;
    logic              wr_acc, rd_acc;

`ifdef FIFO_STROBE_EDGE_EN
    logic wr_q, rd_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= wr;
            rd_q <= rd;
        end
    end

    assign wr_s = wr & ~wr_q;
    assign rd_s = rd & ~rd_q;
`else
    assign wr_s = wr;
    assign rd_s = rd;
`endif

    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_empty = (level_q <= AE_L);
    assign almost_full  = (level_q >= AF_L);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign r_data       = mem_q[r_ptr_q];

    // A full FIFO still takes a write when a read frees the head slot.
    assign wr_acc = wr_s & (~full | (rd_s & ~empty));
    assign rd_acc = rd_s & ~empty;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (wr_acc) begin
            w_ptr_d = w_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            r_ptr_d = r_ptr_q + ADDR_W'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_s && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (rd_s && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_acc) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

endmodule
